// File: rtl/acc_control_fsm.sv
//------------------------------------------------------------------------------
// acc_control_fsm
//   Multicycle control unit for the 16-bit accumulator CPU. It sequences
//   fetch/decode/execute, decodes every datapath select and write enable
//   from the current state, and runs a req/ack handshake with memory.
//   A wait counter aborts a stalled memory access into a terminal BUSERR
//   state.
//
// Parameters:
//   ACK_TIMEOUT - maximum number of wait cycles for MemAck (0 = no timeout)
//
// Optional feature (compile-time macro):
//   ACC_STACK_OPS_EN - when defined, PUSH (A) / POP (B) and their states
//                      exist. When undefined, A/B are illegal and SPWrite
//                      is constant 0.
//
// Ports:
//   CLK       in   rising-edge clock
//   Reset     in   asynchronous active-low reset
//   Opcode    in   IR[15:12], valid from DECODE onward
//   Zero      in   ALU zero flag (combinational)
//   MemAck    in   memory completion pulse
//   MemReq    out  memory request, held until MemAck
//   MemWE     out  memory write (data = ACC)
//   AddrSel   out  address: 0 = PC, 1 = ZE operand, 2 = SP
//   IRWrite/MDRWrite/PCWrite/ACCWrite/SPWrite  out  register write enables
//   PCSrc     out  0 = ALU result, 1 = ALUOut register
//   ACCSrc    out  0 = ALUOut register, 1 = MDR
//   SrcA      out  0 = PC, 1 = ACC, 2 = SP
//   SrcB      out  0 = const 2, 1 = SE, 2 = MDR, 3 = ZE, 4 = SL1
//   ALUOP     out  0 ADD, 1 SUB, 2 AND, 3 OR, 5 PASSA
//   Halted/Illegal/BusErr  out  sticky status (terminal states)
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acc_control_fsm #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  input  logic       MemAck,
  output logic       MemReq,
  output logic       MemWE,
  output logic [1:0] AddrSel,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       PCWrite,
  output logic       ACCWrite,
  output logic       SPWrite,
  output logic       PCSrc,
  output logic       ACCSrc,
  output logic [1:0] SrcA,
  output logic [2:0] SrcB,
  output logic [2:0] ALUOP,
  output logic       Halted,
  output logic       Illegal,
  output logic       BusErr
);

  // The wait counter is 8 bits wide, so only the low byte of the limit matters.
  localparam logic [7:0] TIMEOUT_VAL = 8'(ACK_TIMEOUT);
  localparam bit         TIMEOUT_EN  = (ACK_TIMEOUT != 0);

  localparam logic [4:0] S_FETCH   = 5'd0;
  localparam logic [4:0] S_DECODE  = 5'd1;
  localparam logic [4:0] S_MEMRD   = 5'd2;
  localparam logic [4:0] S_ALUMEM  = 5'd3;
  localparam logic [4:0] S_ALUIMM  = 5'd4;
  localparam logic [4:0] S_ACCWB   = 5'd5;
  localparam logic [4:0] S_LDWB    = 5'd6;
  localparam logic [4:0] S_STORE   = 5'd7;
  localparam logic [4:0] S_BRANCH  = 5'd8;
  localparam logic [4:0] S_JUMP    = 5'd9;
  localparam logic [4:0] S_HALT    = 5'd10;
  localparam logic [4:0] S_ILLEGAL = 5'd11;
  localparam logic [4:0] S_BUSERR  = 5'd12;
`ifdef ACC_STACK_OPS_EN
  localparam logic [4:0] S_PUSH1   = 5'd13;
  localparam logic [4:0] S_PUSH2   = 5'd14;
  localparam logic [4:0] S_POP1    = 5'd15;
  localparam logic [4:0] S_POP2    = 5'd16;
`endif

  logic [4:0] state;
  logic [4:0] state_next;
  logic [7:0] wait_cnt;
  logic       started;
  logic       mem_state;
  logic       ack_timeout;

  // 'started' holds every output at 0 while reset is low and for the
  // remainder of the release cycle; FETCH begins on the first rising edge.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= S_FETCH;
      started  <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      started <= 1'b1;
      if (started) begin
        state <= state_next;
      end
      // Still waiting in the same memory state: count; any exit clears,
      // so every memory state is entered with a zero count.
      if (started && mem_state && !MemAck && !ack_timeout) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  always_comb begin
    mem_state = 1'b0;
    case (state)
      S_FETCH, S_MEMRD, S_STORE: mem_state = 1'b1;
`ifdef ACC_STACK_OPS_EN
      S_PUSH2, S_POP1:           mem_state = 1'b1;
`endif
      default:                   mem_state = 1'b0;
    endcase
  end

  // MemAck in the limit cycle takes priority over the timeout.
  assign ack_timeout = TIMEOUT_EN && mem_state && !MemAck && (wait_cnt == TIMEOUT_VAL);

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (MemAck) state_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4: state_next = S_MEMRD;
          4'h5:                         state_next = S_STORE;
          4'h6, 4'h7:                   state_next = S_ALUIMM;
          4'h8:                         state_next = S_BRANCH;
          4'h9:                         state_next = S_JUMP;
`ifdef ACC_STACK_OPS_EN
          4'hA:                         state_next = S_PUSH1;
          4'hB:                         state_next = S_POP1;
`endif
          4'hF:                         state_next = S_HALT;
          default:                      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMRD:  if (MemAck) state_next = (Opcode == 4'h4) ? S_LDWB : S_ALUMEM;
      S_ALUMEM, S_ALUIMM: state_next = S_ACCWB;
      S_ACCWB, S_LDWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_STORE:  if (MemAck) state_next = S_FETCH;
`ifdef ACC_STACK_OPS_EN
      S_PUSH1:  state_next = S_PUSH2;
      S_PUSH2:  if (MemAck) state_next = S_FETCH;
      S_POP1:   if (MemAck) state_next = S_POP2;
      S_POP2:   state_next = S_FETCH;
`endif
      S_HALT, S_ILLEGAL, S_BUSERR: state_next = state;
      default:  state_next = S_ILLEGAL;
    endcase
    if (ack_timeout) begin
      state_next = S_BUSERR;
    end
  end

  // All-zero defaults select SrcA = PC, SrcB = const 2, ALUOP = ADD.
  always_comb begin
    MemReq   = 1'b0;
    MemWE    = 1'b0;
    AddrSel  = 2'd0;
    IRWrite  = 1'b0;
    MDRWrite = 1'b0;
    PCWrite  = 1'b0;
    ACCWrite = 1'b0;
    SPWrite  = 1'b0;
    PCSrc    = 1'b0;
    ACCSrc   = 1'b0;
    SrcA     = 2'd0;
    SrcB     = 3'd0;
    ALUOP    = 3'd0;
    Halted   = 1'b0;
    Illegal  = 1'b0;
    BusErr   = 1'b0;
    if (started) begin
      case (state)
        S_FETCH: begin
          MemReq  = 1'b1;
          IRWrite = MemAck;
          PCWrite = MemAck;   // PC + 2 straight from the ALU
        end
        S_DECODE: SrcB = 3'd4;  // PC + SL1 -> ALUOut (branch/jump target)
        S_MEMRD: begin
          MemReq   = 1'b1;
          AddrSel  = 2'd1;
          MDRWrite = MemAck;
        end
        S_ALUMEM: begin
          SrcA  = 2'd1;
          SrcB  = 3'd2;
          ALUOP = Opcode[2:0];  // opcodes 0..3 map directly onto ALU ops
        end
        S_ALUIMM: begin
          SrcA = 2'd1;
          if (Opcode[0]) begin  // ORI
            SrcB  = 3'd3;
            ALUOP = 3'd3;
          end else begin        // ADDI
            SrcB  = 3'd1;
          end
        end
        S_ACCWB: ACCWrite = 1'b1;
        S_LDWB: begin
          ACCWrite = 1'b1;
          ACCSrc   = 1'b1;
        end
        S_STORE: begin
          MemReq  = 1'b1;
          MemWE   = 1'b1;
          AddrSel = 2'd1;
        end
        S_BRANCH: begin
          SrcA    = 2'd1;
          ALUOP   = 3'd5;
          PCWrite = Zero;
          PCSrc   = Zero;
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = 1'b1;
        end
`ifdef ACC_STACK_OPS_EN
        S_PUSH1: begin
          SrcA    = 2'd2;
          ALUOP   = 3'd1;
          SPWrite = 1'b1;
        end
        S_PUSH2: begin
          MemReq  = 1'b1;
          MemWE   = 1'b1;
          AddrSel = 2'd2;
        end
        S_POP1: begin
          MemReq   = 1'b1;
          AddrSel  = 2'd2;
          MDRWrite = MemAck;
        end
        S_POP2: begin
          SrcA     = 2'd2;
          SPWrite  = 1'b1;
          ACCWrite = 1'b1;
          ACCSrc   = 1'b1;
        end
`endif
        S_HALT:    Halted  = 1'b1;
        S_ILLEGAL: Illegal = 1'b1;
        S_BUSERR:  BusErr  = 1'b1;
        default:   ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_acc_control_fsm.sv
//------------------------------------------------------------------------------
// tb_acc_control_fsm
//   Directed self-checking bench for acc_control_fsm. Two instances share the
//   inputs: 'dut' with the default ACK_TIMEOUT and 'dut_to' with
//   ACK_TIMEOUT = 3. Outputs are packed into a 22-bit control word:
//   {MemReq, MemWE, AddrSel, IRWrite, MDRWrite, PCWrite, ACCWrite, SPWrite,
//    PCSrc, ACCSrc, SrcA, SrcB, ALUOP, Halted, Illegal, BusErr}
//   Stack tests follow the ACC_STACK_OPS_EN macro.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_acc_control_fsm;

  logic       CLK;
  logic       Reset;
  logic [3:0] Opcode;
  logic       Zero;
  logic       MemAck;

  logic       MemReq, MemWE, IRWrite, MDRWrite, PCWrite, ACCWrite, SPWrite;
  logic       PCSrc, ACCSrc, Halted, Illegal, BusErr;
  logic [1:0] AddrSel, SrcA;
  logic [2:0] SrcB, ALUOP;

  logic       t_MemReq, t_MemWE, t_IRWrite, t_MDRWrite, t_PCWrite, t_ACCWrite, t_SPWrite;
  logic       t_PCSrc, t_ACCSrc, t_Halted, t_Illegal, t_BusErr;
  logic [1:0] t_AddrSel, t_SrcA;
  logic [2:0] t_SrcB, t_ALUOP;

  int total  = 0;
  int passed = 0;

  acc_control_fsm dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemAck(MemAck),
    .MemReq(MemReq), .MemWE(MemWE), .AddrSel(AddrSel), .IRWrite(IRWrite),
    .MDRWrite(MDRWrite), .PCWrite(PCWrite), .ACCWrite(ACCWrite), .SPWrite(SPWrite),
    .PCSrc(PCSrc), .ACCSrc(ACCSrc), .SrcA(SrcA), .SrcB(SrcB), .ALUOP(ALUOP),
    .Halted(Halted), .Illegal(Illegal), .BusErr(BusErr)
  );

  acc_control_fsm #(.ACK_TIMEOUT(3)) dut_to (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemAck(MemAck),
    .MemReq(t_MemReq), .MemWE(t_MemWE), .AddrSel(t_AddrSel), .IRWrite(t_IRWrite),
    .MDRWrite(t_MDRWrite), .PCWrite(t_PCWrite), .ACCWrite(t_ACCWrite), .SPWrite(t_SPWrite),
    .PCSrc(t_PCSrc), .ACCSrc(t_ACCSrc), .SrcA(t_SrcA), .SrcB(t_SrcB), .ALUOP(t_ALUOP),
    .Halted(t_Halted), .Illegal(t_Illegal), .BusErr(t_BusErr)
  );

  wire [21:0] ctl = {MemReq, MemWE, AddrSel, IRWrite, MDRWrite, PCWrite, ACCWrite,
                     SPWrite, PCSrc, ACCSrc, SrcA, SrcB, ALUOP, Halted, Illegal, BusErr};
  wire [21:0] ctl_t = {t_MemReq, t_MemWE, t_AddrSel, t_IRWrite, t_MDRWrite, t_PCWrite,
                       t_ACCWrite, t_SPWrite, t_PCSrc, t_ACCSrc, t_SrcA, t_SrcB, t_ALUOP,
                       t_Halted, t_Illegal, t_BusErr};

  // Expected control words: {mem(4), we(5), src(2), SrcA, SrcB, ALUOP, status(3)}
  localparam logic [21:0] X_IDLE      = 22'd0;
  localparam logic [21:0] X_FETCH     = {4'b1000, 5'b00000, 2'b00, 2'd0, 3'd0, 3'd0, 3'b000};
  localparam logic [21:0] X_FETCH_ACK = {4'b1000, 5'b10100, 2'b00, 2'd0, 3'd0, 3'd0, 3'b000};
  localparam logic [21:0] X_DECODE    = {4'b0000, 5'b00000, 2'b00, 2'd0, 3'd4, 3'd0, 3'b000};
  localparam logic [21:0] X_MEMRD_ACK = {4'b1001, 5'b01000, 2'b00, 2'd0, 3'd0, 3'd0, 3'b000};
  localparam logic [21:0] X_ACCWB     = {4'b0000, 5'b00010, 2'b00, 2'd0, 3'd0, 3'd0, 3'b000};
  localparam logic [21:0] X_LDWB      = {4'b0000, 5'b00010, 2'b01, 2'd0, 3'd0, 3'd0, 3'b000};
  localparam logic [21:0] X_ADDI      = {4'b0000, 5'b00000, 2'b00, 2'd1, 3'd1, 3'd0, 3'b000};
  localparam logic [21:0] X_ORI       = {4'b0000, 5'b00000, 2'b00, 2'd1, 3'd3, 3'd3, 3'b000};
  localparam logic [21:0] X_STORE     = {4'b1101, 5'b00000, 2'b00, 2'd0, 3'd0, 3'd0, 3'b000};
  localparam logic [21:0] X_BR_T      = {4'b0000, 5'b00100, 2'b10, 2'd1, 3'd0, 3'd5, 3'b000};
  localparam logic [21:0] X_BR_N      = {4'b0000, 5'b00000, 2'b00, 2'd1, 3'd0, 3'd5, 3'b000};
  localparam logic [21:0] X_JUMP      = {4'b0000, 5'b00100, 2'b10, 2'd0, 3'd0, 3'd0, 3'b000};
  localparam logic [21:0] X_HALT      = {19'd0, 3'b100};
  localparam logic [21:0] X_ILL       = {19'd0, 3'b010};
  localparam logic [21:0] X_BUSERR    = {19'd0, 3'b001};
`ifdef ACC_STACK_OPS_EN
  localparam logic [21:0] X_PUSH1     = {4'b0000, 5'b00001, 2'b00, 2'd2, 3'd0, 3'd1, 3'b000};
  localparam logic [21:0] X_PUSH2     = {4'b1110, 5'b00000, 2'b00, 2'd0, 3'd0, 3'd0, 3'b000};
  localparam logic [21:0] X_POP1_ACK  = {4'b1010, 5'b01000, 2'b00, 2'd0, 3'd0, 3'd0, 3'b000};
  localparam logic [21:0] X_POP2      = {4'b0000, 5'b00011, 2'b01, 2'd2, 3'd0, 3'd0, 3'b000};
`endif

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "time limit reached");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Holds reset for three cycles and releases it just after an edge;
  // the next tick lands in the first FETCH cycle.
  task automatic do_reset();
    Reset  = 1'b0;
    MemAck = 1'b0;
    Zero   = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
  endtask

  // Zero-wait fetch and decode of 'op'; returns one tick into the dispatched state.
  task automatic run_fetch_decode(input logic [3:0] op);
    do_reset();
    Opcode = op;
    tick();
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0; MemAck = 1'b0; Zero = 1'b0; Opcode = 4'h0;
    repeat (3) tick();
    total++; if (ctl !== X_IDLE) $display("FAIL reset_held: got %h want %h", ctl, X_IDLE); else passed++;
    Reset = 1'b1;
    #1;
    total++; if (ctl !== X_IDLE) $display("FAIL reset_release_cycle: got %h want %h", ctl, X_IDLE); else passed++;
    tick();
    total++; if (ctl !== X_FETCH) $display("FAIL first_fetch: got %h want %h", ctl, X_FETCH); else passed++;
    tick();
    total++; if (ctl !== X_FETCH) $display("FAIL fetch_waits: got %h want %h", ctl, X_FETCH); else passed++;
  endtask

  task automatic test_alu_imm();
    do_reset();
    Opcode = 4'h6;
    tick();
    MemAck = 1'b1; #1;
    total++; if (ctl !== X_FETCH_ACK) $display("FAIL addi_fetch: got %h want %h", ctl, X_FETCH_ACK); else passed++;
    tick(); MemAck = 1'b0; #1;
    total++; if (ctl !== X_DECODE) $display("FAIL addi_decode: got %h want %h", ctl, X_DECODE); else passed++;
    tick(); #1;
    total++; if (ctl !== X_ADDI) $display("FAIL addi_exec: got %h want %h", ctl, X_ADDI); else passed++;
    tick(); #1;
    total++; if (ctl !== X_ACCWB) $display("FAIL addi_wb_cycle4: got %h want %h", ctl, X_ACCWB); else passed++;
    tick(); #1;
    total++; if (ctl !== X_FETCH) $display("FAIL addi_next_fetch: got %h want %h", ctl, X_FETCH); else passed++;
    run_fetch_decode(4'h7); #1;
    total++; if (ctl !== X_ORI) $display("FAIL ori_exec: got %h want %h", ctl, X_ORI); else passed++;
    tick(); #1;
    total++; if (ctl !== X_ACCWB) $display("FAIL ori_wb: got %h want %h", ctl, X_ACCWB); else passed++;
  endtask

  task automatic test_alu_mem();
    logic [21:0] exp_alu;
    for (int op = 0; op < 4; op++) begin
      exp_alu = {4'b0000, 5'b00000, 2'b00, 2'd1, 3'd2, op[2:0], 3'b000};
      run_fetch_decode(op[3:0]);
      MemAck = 1'b1; #1;
      total++; if (ctl !== X_MEMRD_ACK) $display("FAIL memrd_op%0d: got %h want %h", op, ctl, X_MEMRD_ACK); else passed++;
      tick(); MemAck = 1'b0; #1;
      total++; if (ctl !== exp_alu) $display("FAIL alumem_op%0d: got %h want %h", op, ctl, exp_alu); else passed++;
      tick(); #1;
      total++; if (ctl !== X_ACCWB) $display("FAIL accwb_op%0d: got %h want %h", op, ctl, X_ACCWB); else passed++;
    end
    tick(); #1;
    total++; if (ctl !== X_FETCH) $display("FAIL alumem_next_fetch: got %h want %h", ctl, X_FETCH); else passed++;
  endtask

  task automatic test_load();
    run_fetch_decode(4'h4);
    MemAck = 1'b1; #1;
    total++; if (ctl !== X_MEMRD_ACK) $display("FAIL lda_memrd: got %h want %h", ctl, X_MEMRD_ACK); else passed++;
    tick(); MemAck = 1'b0; #1;
    total++; if (ctl !== X_LDWB) $display("FAIL lda_wb: got %h want %h", ctl, X_LDWB); else passed++;
    tick(); #1;
    total++; if (ctl !== X_FETCH) $display("FAIL lda_next_fetch: got %h want %h", ctl, X_FETCH); else passed++;
  endtask

  task automatic test_branch_jump();
    run_fetch_decode(4'h8);
    Zero = 1'b1; #1;
    total++; if (ctl !== X_BR_T) $display("FAIL beqz_taken: got %h want %h", ctl, X_BR_T); else passed++;
    tick(); Zero = 1'b0; #1;
    total++; if (ctl !== X_FETCH) $display("FAIL beqz_taken_fetch: got %h want %h", ctl, X_FETCH); else passed++;
    run_fetch_decode(4'h8);
    Zero = 1'b0; #1;
    total++; if (ctl !== X_BR_N) $display("FAIL beqz_not_taken: got %h want %h", ctl, X_BR_N); else passed++;
    Zero = 1'b1; #1;
    total++; if (ctl !== X_BR_T) $display("FAIL beqz_zero_comb: got %h want %h", ctl, X_BR_T); else passed++;
    Zero = 1'b0;
    tick(); #1;
    total++; if (ctl !== X_FETCH) $display("FAIL beqz_seq_fetch: got %h want %h", ctl, X_FETCH); else passed++;
    run_fetch_decode(4'h9); #1;
    total++; if (ctl !== X_JUMP) $display("FAIL jmp: got %h want %h", ctl, X_JUMP); else passed++;
    tick(); #1;
    total++; if (ctl !== X_FETCH) $display("FAIL jmp_fetch: got %h want %h", ctl, X_FETCH); else passed++;
  endtask

  task automatic test_store_wait();
    run_fetch_decode(4'h5);
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ctl !== X_STORE) $display("FAIL sta_wait%0d: got %h want %h", i, ctl, X_STORE); else passed++;
      tick();
    end
    MemAck = 1'b1; #1;
    total++; if (ctl !== X_STORE) $display("FAIL sta_ack_cycle: got %h want %h", ctl, X_STORE); else passed++;
    tick(); MemAck = 1'b0; #1;
    total++; if (ctl !== X_FETCH) $display("FAIL sta_next_fetch: got %h want %h", ctl, X_FETCH); else passed++;
  endtask

  task automatic test_timeout();
    // dut_to: counts 0..3 with MemReq held, then BUSERR.
    run_fetch_decode(4'h5);
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ctl_t !== X_STORE) $display("FAIL to_wait%0d: got %h want %h", i, ctl_t, X_STORE); else passed++;
      tick();
    end
    #1;
    total++; if (ctl_t !== X_BUSERR) $display("FAIL to_buserr: got %h want %h", ctl_t, X_BUSERR); else passed++;
    total++; if (ctl !== X_STORE) $display("FAIL to_default_still_waiting: got %h want %h", ctl, X_STORE); else passed++;
    tick(); MemAck = 1'b1; #1;
    total++; if (ctl_t !== X_BUSERR) $display("FAIL to_buserr_sticky: got %h want %h", ctl_t, X_BUSERR); else passed++;
    MemAck = 1'b0;
    // Asynchronous reset in the middle of the default instance's STORE handshake.
    Reset = 1'b0; #1;
    total++; if (ctl_t !== X_IDLE) $display("FAIL to_reset_clears: got %h want %h", ctl_t, X_IDLE); else passed++;
    total++; if (ctl !== X_IDLE) $display("FAIL reset_mid_store: got %h want %h", ctl, X_IDLE); else passed++;
    // MemAck on the limit cycle wins over the timeout.
    run_fetch_decode(4'h5);
    repeat (3) tick();
    MemAck = 1'b1; #1;
    total++; if (ctl_t !== X_STORE) $display("FAIL to_limit_cycle: got %h want %h", ctl_t, X_STORE); else passed++;
    tick(); MemAck = 1'b0; #1;
    total++; if (ctl_t !== X_FETCH) $display("FAIL to_ack_wins: got %h want %h", ctl_t, X_FETCH); else passed++;
  endtask

  task automatic test_illegal_halt();
    run_fetch_decode(4'hD); #1;
    total++; if (ctl !== X_ILL) $display("FAIL illegal_d: got %h want %h", ctl, X_ILL); else passed++;
    repeat (3) tick();
    MemAck = 1'b1; #1;
    total++; if (ctl !== X_ILL) $display("FAIL illegal_held: got %h want %h", ctl, X_ILL); else passed++;
    tick(); MemAck = 1'b0; #1;
    total++; if (ctl !== X_ILL) $display("FAIL illegal_ignores_ack: got %h want %h", ctl, X_ILL); else passed++;
    run_fetch_decode(4'hC); #1;
    total++; if (ctl !== X_ILL) $display("FAIL illegal_c: got %h want %h", ctl, X_ILL); else passed++;
    run_fetch_decode(4'hF); #1;
    total++; if (ctl !== X_HALT) $display("FAIL halt: got %h want %h", ctl, X_HALT); else passed++;
    MemAck = 1'b1;
    tick(); MemAck = 1'b0; #1;
    total++; if (ctl !== X_HALT) $display("FAIL halt_held: got %h want %h", ctl, X_HALT); else passed++;
  endtask

`ifdef ACC_STACK_OPS_EN
  task automatic test_stack();
    run_fetch_decode(4'hA); #1;
    total++; if (ctl !== X_PUSH1) $display("FAIL push1: got %h want %h", ctl, X_PUSH1); else passed++;
    tick(); #1;
    total++; if (ctl !== X_PUSH2) $display("FAIL push2: got %h want %h", ctl, X_PUSH2); else passed++;
    tick(); #1;
    total++; if (ctl !== X_PUSH2) $display("FAIL push2_wait: got %h want %h", ctl, X_PUSH2); else passed++;
    Reset = 1'b0; #1;
    total++; if (ctl !== X_IDLE) $display("FAIL reset_mid_push2: got %h want %h", ctl, X_IDLE); else passed++;
    tick(); Reset = 1'b1;
    tick(); #1;
    total++; if (ctl !== X_FETCH) $display("FAIL push_reset_fetch: got %h want %h", ctl, X_FETCH); else passed++;
    run_fetch_decode(4'hB);
    MemAck = 1'b1; #1;
    total++; if (ctl !== X_POP1_ACK) $display("FAIL pop1: got %h want %h", ctl, X_POP1_ACK); else passed++;
    tick(); MemAck = 1'b0; #1;
    total++; if (ctl !== X_POP2) $display("FAIL pop2: got %h want %h", ctl, X_POP2); else passed++;
    tick(); #1;
    total++; if (ctl !== X_FETCH) $display("FAIL pop_fetch: got %h want %h", ctl, X_FETCH); else passed++;
  endtask
`else
  task automatic test_stack_disabled();
    run_fetch_decode(4'hA); #1;
    total++; if (ctl !== X_ILL) $display("FAIL push_disabled: got %h want %h", ctl, X_ILL); else passed++;
    run_fetch_decode(4'hB); #1;
    total++; if (ctl !== X_ILL) $display("FAIL pop_disabled: got %h want %h", ctl, X_ILL); else passed++;
  endtask
`endif

  initial begin
    Reset  = 1'b0;
    MemAck = 1'b0;
    Zero   = 1'b0;
    Opcode = 4'h0;
    test_reset();
    test_alu_imm();
    test_alu_mem();
    test_load();
    test_branch_jump();
    test_store_wait();
    test_timeout();
    test_illegal_halt();
`ifdef ACC_STACK_OPS_EN
    test_stack();
`else
    test_stack_disabled();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/acc_control_fsm.md
# acc_control_fsm

Multicycle control unit for the 16-bit accumulator CPU. It is the controller that drives the ALU operand-select, ALU-operation and ALUOut-feeding datapath: it sequences fetch/decode/execute, generates every select and write-enable that the datapath consumes, and runs a req/ack handshake with instruction/data memory. It consumes the ALU `Zero` flag and the IR opcode field.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 255. Maximum number of cycles to wait for `MemAck`. A value of 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Opcode`  in  4  IR[15:12]; valid from DECODE onward
- `Zero`  in  1  ALU zero flag (combinational ALU output)
- `MemAck`  in  1  memory completion, single-cycle pulse
- `MemReq`  out  1  memory request, held until `MemAck`
- `MemWE`  out  1  1 = write (write data = ACC)
- `AddrSel`  out  2  memory address: 0 = PC, 1 = ZE operand, 2 = SP
- `IRWrite`, `MDRWrite`, `PCWrite`, `ACCWrite`, `SPWrite`  out  1 each  register write enables
- `PCSrc`  out  1  0 = ALU Out, 1 = ALUOut register
- `ACCSrc`  out  1  0 = ALUOut register, 1 = MDR
- `SrcA`  out  2  0 = PC, 1 = ACC, 2 = SP
- `SrcB`  out  3  0 = const 2, 1 = SE, 2 = MDR, 3 = ZE, 4 = SL1
- `ALUOP`  out  3  0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 5 = PASSA
- `Halted`, `Illegal`, `BusErr`  out  1 each  sticky status flags

## Operation
- Outputs are decoded from state. Default for every output is 0, which gives `SrcA` = PC, `SrcB` = 2, `ALUOP` = ADD.
- Opcodes: 0 ADD m, 1 SUB m, 2 AND m, 3 OR m, 4 LDA m, 5 STA m, 6 ADDI (SE), 7 ORI (ZE), 8 BEQZ, 9 JMP, A PUSH, B POP, F HALT. All other opcodes are illegal.

States:
- **FETCH**
  - Drives `AddrSel` = 0 and `MemReq` = 1.
  - In the `MemAck` cycle it also asserts `IRWrite`, `PCWrite` with `PCSrc` = 0, and `SrcA` = PC, `SrcB` = 2, ADD. This gives PC += 2.
  - Goes to DECODE.
- **DECODE**
  - Drives `SrcA` = PC, `SrcB` = SL1, ADD. ALUOut captures the branch/jump target.
  - Dispatch: 0–4 → MEMRD; 5 → STORE; 6/7 → ALUIMM; 8 → BRANCH; 9 → JUMP; A → PUSH1; B → POP1; F → HALT; anything else → ILLEGAL.
- **MEMRD**
  - Drives `AddrSel` = 1 and `MemReq`. On `MemAck` it asserts `MDRWrite`.
  - Goes to LDWB for LDA, otherwise ALUMEM.
- **ALUMEM**
  - Drives `SrcA` = ACC, `SrcB` = MDR, `ALUOP` = opcode[2:0].
  - Goes to ACCWB.
- **ALUIMM**
  - Drives `SrcA` = ACC. ADDI uses `SrcB` = SE with ADD; ORI uses `SrcB` = ZE with OR.
  - Goes to ACCWB.
- **ACCWB**: asserts `ACCWrite` with `ACCSrc` = 0, then goes to FETCH.
- **LDWB**: asserts `ACCWrite` with `ACCSrc` = 1, then goes to FETCH.
- **STORE**
  - Drives `AddrSel` = 1, `MemReq` and `MemWE`.
  - Goes to FETCH on `MemAck`.
- **BRANCH**
  - Drives `SrcA` = ACC with PASSA.
  - If `Zero` = 1, asserts `PCWrite` with `PCSrc` = 1.
  - Goes to FETCH.
- **JUMP**: asserts `PCWrite` with `PCSrc` = 1, then goes to FETCH.
- **PUSH1**: drives `SrcA` = SP, `SrcB` = 2, SUB, and asserts `SPWrite`. Goes to PUSH2.
- **PUSH2**: drives `AddrSel` = 2, `MemReq` and `MemWE`. Goes to FETCH on `MemAck`.
- **POP1**: drives `AddrSel` = 2 and `MemReq`; asserts `MDRWrite` on `MemAck`. Goes to POP2.
- **POP2**: drives `SrcA` = SP, `SrcB` = 2, ADD, and asserts `SPWrite`, plus `ACCWrite` with `ACCSrc` = 1. Goes to FETCH.
- **HALT**: `Halted` = 1, terminal. **ILLEGAL**: `Illegal` = 1, terminal. **BUSERR**: `BusErr` = 1, terminal. Only reset leaves a terminal state.

Memory handshake:
- `MemReq` and `MemWE` stay stable from the first cycle of a memory state until the `MemAck` cycle inclusive.
- `MemReq` drops in the cycle after `MemAck`.
- A `MemAck` outside a memory state is ignored.

Timeout:
- A wait counter (8 bits) clears on entry to every memory state and increments every cycle without `MemAck`.
- When the counter equals `ACK_TIMEOUT` without `MemAck`, the FSM goes to BUSERR and `MemReq` drops.
- If `MemAck` arrives in the same cycle the counter reaches `ACK_TIMEOUT`, `MemAck` wins.

## Timing
- Reset low, at any time and including mid-handshake: state = FETCH, wait counter = 0, all outputs 0 immediately (asynchronous). Status flags clear.
- First rising edge after `Reset` releases: FETCH drives `MemReq` = 1.
- Cycle counts with zero-wait memory (`MemAck` in the first request cycle):
  - ADDI/ORI: 4 (FETCH, DECODE, ALUIMM, ACCWB)
  - ADD m: 5; LDA: 4; STA: 3
  - BEQZ/JMP: 3
  - PUSH/POP: 4
- Each cycle of `MemAck` latency adds 1 cycle per memory access.
- `Zero` is sampled combinationally in BRANCH. `PCWrite` is asserted in that same cycle.

## Configuration
- `ACC_STACK_OPS_EN`
  - Defined: PUSH/POP and the PUSH1/PUSH2/POP1/POP2 states exist; `SPWrite` and `AddrSel` = 2 are reachable.
  - Undefined: opcodes A and B dispatch to ILLEGAL, `SPWrite` is tied to 0, and the stack states are not compiled.

## Test plan
- Reset low 3 cycles, then release, with `MemAck` = 1 every request and IR = 0x6005 (ADDI 5), ACC = 0 → ACCWrite in cycle 4 with ACC = 5; PC advances 0 → 2.
- BEQZ with ACC = 0, target PC + SL1 = 0x0010 → `PCWrite` = 1 with `PCSrc` = 1 in BRANCH. Repeat with ACC = 3 → `PCWrite` = 0, next fetch at the sequential PC.
- STA with `MemAck` delayed 4 cycles → `MemReq` = `MemWE` = 1 steady for 5 cycles, `AddrSel` = 1, then FETCH.
- `ACK_TIMEOUT` = 3, `MemAck` never asserted → BUSERR after 3 wait cycles, `BusErr` = 1, `MemReq` = 0. Reset then clears `BusErr`.
- Opcode 0xD → ILLEGAL, `Illegal` = 1 and held. Opcode 0xF → `Halted` = 1. With `ACC_STACK_OPS_EN` undefined, opcode 0xA → ILLEGAL.
- PUSH with SP = 0x0100 → `SPWrite` in PUSH1 (SP becomes 0x00FE), then a write with `AddrSel` = 2. Assert `Reset` low mid-PUSH2 → all outputs 0 immediately, FETCH after release.
